sonar_scheduler: RTL

SONAR_SCHEDULER -- requirements
Module: sonar_scheduler

---
 rtl/sonar_scheduler.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sonar_scheduler.sv
// rtl/sonar_scheduler.sv - round-robin HC-SR04 trigger/echo scheduler with a single result register
// Optional echo deglitch filter: define SONAR_SCHED_DEGLITCH_EN.
`timescale 1ns/1ps
module sonar_scheduler #(
    parameter int N_SENSORS     = 4,
    parameter int CLK_PER_US    = 40,
    parameter int TRIG_US       = 20,
    parameter int SLOT_US       = 15000,
    parameter int ECHO_START_US = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N_SENSORS-1:0] sensor_en,
    input  logic [N_SENSORS-1:0] echo,
    output logic [N_SENSORS-1:0] trig,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2:0]           res_id,
    output logic [11:0]          res_us,
    output logic                 res_timeout,
    output logic                 res_overrun
);

    localparam int TW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int SW = $clog2(SLOT_US + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_PER_US - 1);
    localparam logic [SW-1:0] TRIG_LAST = SW'(TRIG_US - 1);
    localparam logic [SW-1:0] WAIT_LAST = SW'(TRIG_US + ECHO_START_US - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_US - 1);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF} state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          tick_cnt;
    logic                   tick;
    logic [SW-1:0]          slot_cnt;
    logic [11:0]            meas_cnt;
    logic [2:0]             rr_id;
    logic [2:0]             next_id;
    logic                   found;
    logic [N_SENSORS-1:0]   echo_m, echo_s;
    logic                   echo_raw;
    logic                   echo_lvl;
    logic                   slot_start;
    logic                   report;
    logic [11:0]            rep_us;
    logic                   rep_to;
    logic                   meas_load1;
    logic                   meas_inc;

    // two-flop synchronizer on every raw echo pin
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            echo_m <= '0;
            echo_s <= '0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
        end
    end

    // microsecond tick: one-cycle pulse every CLK_PER_US clocks
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TW'(1);
    end
    assign tick = (tick_cnt == TICK_LAST);

    // pick the selected channel's synchronized echo; other channels are ignored
    always_comb begin
        echo_raw = 1'b0;
        for (int i = 0; i < N_SENSORS; i++)
            if (rr_id == 3'(i))
                echo_raw = echo_s[i];
    end

`ifdef SONAR_SCHED_DEGLITCH_EN
    logic [1:0] hist;
    logic       filt_q;

    // level changes only once three consecutive tick samples agree
    assign echo_lvl = (echo_raw == hist[0] && echo_raw == hist[1]) ? echo_raw : filt_q;

    // tick-sampled history of the selected echo, cleared at each slot start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist   <= '0;
            filt_q <= 1'b0;
        end else if (slot_start) begin
            hist   <= '0;
            filt_q <= 1'b0;
        end else if (tick) begin
            hist   <= {hist[0], echo_raw};
            filt_q <= echo_lvl;
        end
    end
`else
    assign echo_lvl = echo_raw;
`endif

    // round-robin: first enabled channel strictly after rr_id, wrapping
    always_comb begin
        next_id = rr_id;
        found   = 1'b0;
        for (int i = 0; i < N_SENSORS; i++)
            if (!found && sensor_en[i] && (3'(i) > rr_id)) begin
                next_id = 3'(i);
                found   = 1'b1;
            end
        for (int i = 0; i < N_SENSORS; i++)
            if (!found && sensor_en[i]) begin
                next_id = 3'(i);
                found   = 1'b1;
            end
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // next-state and per-tick control; everything advances only on tick
    always_comb begin
        state_d    = state_q;
        slot_start = 1'b0;
        report     = 1'b0;
        rep_us     = 12'd0;
        rep_to     = 1'b0;
        meas_load1 = 1'b0;
        meas_inc   = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (enable && (|sensor_en)) begin
                        state_d    = TRIG;
                        slot_start = 1'b1;
                    end
                end
                TRIG: begin
                    if (slot_cnt == TRIG_LAST)
                        state_d = WAIT_ECHO;
                end
                WAIT_ECHO: begin
                    if (echo_lvl) begin
                        state_d    = MEASURE;
                        meas_load1 = 1'b1;
                    end else if (slot_cnt == WAIT_LAST) begin
                        report  = 1'b1;
                        rep_to  = 1'b1;
                        state_d = HOLDOFF;
                    end
                end
                MEASURE: begin
                    if (!echo_lvl) begin
                        report  = 1'b1;
                        rep_us  = meas_cnt;
                        state_d = HOLDOFF;
                    end else if (meas_cnt == 12'd4094) begin
                        report  = 1'b1;
                        rep_us  = 12'd4095;
                        rep_to  = 1'b1;
                        state_d = HOLDOFF;
                    end else begin
                        meas_inc = 1'b1;
                    end
                end
                HOLDOFF: begin
                    if (slot_cnt == SLOT_LAST) begin
                        if (enable && (|sensor_en)) begin
                            state_d    = TRIG;
                            slot_start = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // slot counter measured from trig rise, plus channel pointer latched at slot start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt <= '0;
            rr_id    <= 3'(N_SENSORS - 1);
        end else if (slot_start) begin
            slot_cnt <= '0;
            rr_id    <= next_id;
        end else if (tick) begin
            if (state_d == IDLE)
                slot_cnt <= '0;
            else
                slot_cnt <= slot_cnt + SW'(1);
        end
    end

    // echo high-time counter in microseconds
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            meas_cnt <= 12'd0;
        else if (meas_load1)
            meas_cnt <= 12'd1;
        else if (meas_inc)
            meas_cnt <= meas_cnt + 12'd1;
    end

    // trigger pin of the selected channel is high only in TRIG
    always_comb begin
        trig = '0;
        for (int i = 0; i < N_SENSORS; i++)
            trig[i] = (state_q == TRIG) && (rr_id == 3'(i));
    end

    // result register: a new report overwrites, flagging overrun unless accepted this cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid   <= 1'b0;
            res_id      <= 3'd0;
            res_us      <= 12'd0;
            res_timeout <= 1'b0;
            res_overrun <= 1'b0;
        end else begin
            res_overrun <= report && res_valid && !res_ready;
            if (report) begin
                res_valid   <= 1'b1;
                res_id      <= rr_id;
                res_us      <= rep_us;
                res_timeout <= rep_to;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule
